// File: rtl/mod_call_arbiter.sv
// Round-robin arbiter that lets four upstream requesters share one
// downstream call port. Each call is a four-phase handshake (CALL, DRAIN)
// guarded by a cycle budget; a blown budget still completes the call
// upstream but raises a sticky error that names the first offender.
module mod_call_arbiter #(
   parameter int N       = 4,
   parameter int WIDTH   = 32,
   parameter int TIMEOUT = 255
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [N-1:0]       up_req,
   input  logic [N*WIDTH-1:0] up_arg,
   output logic [N-1:0]       up_ack,
   output logic               dn_req,
   output logic [WIDTH-1:0]   dn_arg,
   input  logic               dn_ack,
   input  logic               err_clr,
   output logic               busy,
   output logic               timeout_err,
   output logic [1:0]         err_id
);

   localparam int CW = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT);

   typedef enum logic [1:0] {
      IDLE,
      CALL,
      DRAIN,
      DONE
   } state_t;

   state_t           state_q, state_d;
   logic [1:0]       ptr_q, ptr_d;
   logic [1:0]       g_q, g_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             dn_req_q, dn_req_d;
   logic [WIDTH-1:0] dn_arg_q, dn_arg_d;
   logic [N-1:0]     up_ack_q, up_ack_d;
   logic             timeout_err_q, timeout_err_d;
   logic [1:0]       err_id_q, err_id_d;

   logic [1:0]       grant;
   logic [1:0]       idx;
   logic [WIDTH-1:0] grant_arg;
   logic [CW-1:0]    cnt_inc;
   logic             tmo_evt;

   // Round-robin pick: scan downward so the last hit is the requester closest above ptr.
   always_comb begin
      grant = ptr_q;
      idx   = '0;
      for (int k = N - 1; k >= 0; k--) begin
         idx = ptr_q + 2'(k);
         if (up_req[idx]) begin
            grant = idx;
         end
      end
   end

   assign grant_arg = up_arg[int'(grant) * WIDTH +: WIDTH];

   // The call budget saturates instead of wrapping so a stuck downstream cannot alias to a small count.
   assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CW'(1);

   // Call sequencing: grant in IDLE, wait for ack in CALL, wait for ack release in DRAIN, ack upstream in DONE.
   always_comb begin
      state_d  = state_q;
      ptr_d    = ptr_q;
      g_d      = g_q;
      cnt_d    = cnt_q;
      dn_req_d = dn_req_q;
      dn_arg_d = dn_arg_q;
      up_ack_d = '0;
      tmo_evt  = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (|up_req) begin
               g_d      = grant;
               dn_arg_d = grant_arg;
               dn_req_d = 1'b1;
               cnt_d    = '0;
               state_d  = CALL;
            end
         end
         CALL: begin
            cnt_d = cnt_inc;
            if (dn_ack) begin
               dn_req_d = 1'b0;
               state_d  = DRAIN;
            end else if (cnt_inc == CNT_MAX) begin
               dn_req_d = 1'b0;
               tmo_evt  = 1'b1;
               state_d  = DRAIN;
            end
         end
         DRAIN: begin
            cnt_d = cnt_inc;
            if (!dn_ack) begin
               up_ack_d[g_q] = 1'b1;
               state_d       = DONE;
            end else if (cnt_inc == CNT_MAX) begin
               up_ack_d[g_q] = 1'b1;
               tmo_evt       = 1'b1;
               state_d       = DONE;
            end
         end
         DONE: begin
            ptr_d   = g_q + 2'd1;
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Sticky error: a clear in the same cycle as a new timeout loses, and the new offender is recorded.
   always_comb begin
      timeout_err_d = timeout_err_q;
      err_id_d      = err_id_q;
      if (err_clr) begin
         timeout_err_d = 1'b0;
         err_id_d      = '0;
      end
      if (tmo_evt) begin
         if (!timeout_err_d) begin
            err_id_d = g_q;
         end
         timeout_err_d = 1'b1;
      end
   end

   // State and output registers; reset abandons any call in flight without acking it.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q       <= IDLE;
         ptr_q         <= '0;
         g_q           <= '0;
         cnt_q         <= '0;
         dn_req_q      <= 1'b0;
         dn_arg_q      <= '0;
         up_ack_q      <= '0;
         timeout_err_q <= 1'b0;
         err_id_q      <= '0;
      end else begin
         state_q       <= state_d;
         ptr_q         <= ptr_d;
         g_q           <= g_d;
         cnt_q         <= cnt_d;
         dn_req_q      <= dn_req_d;
         dn_arg_q      <= dn_arg_d;
         up_ack_q      <= up_ack_d;
         timeout_err_q <= timeout_err_d;
         err_id_q      <= err_id_d;
      end
   end

   assign up_ack      = up_ack_q;
   assign dn_req      = dn_req_q;
   assign dn_arg      = dn_arg_q;
   assign busy        = (state_q != IDLE);
   assign timeout_err = timeout_err_q;
   assign err_id      = err_id_q;

endmodule

// File: tb/tb_mod_call_arbiter.sv
// Bench for mod_call_arbiter: directed scenarios followed by random traffic,
// all checked every cycle against a call-level model that predicts each
// call's winner, argument and phase lengths from the downstream delay.
module tb_mod_call_arbiter;

   localparam int TMO = 12;

   logic         clk;
   logic         rst_n;
   logic [3:0]   up_req;
   logic [127:0] up_arg;
   logic [3:0]   up_ack;
   logic         dn_req;
   logic [31:0]  dn_arg;
   logic         dn_ack;
   logic         err_clr;
   logic         busy;
   logic         timeout_err;
   logic [1:0]   err_id;

   logic [31:0]  args [4];
   logic [7:0]   dnHist;
   logic [2:0]   dsSel;
   logic         ackStuck;
   logic         autoRe;

   int           vectorCount = 0;
   int           missCount   = 0;

   // Call-level model state
   int           mN;
   int           mC;
   int           mEnd;
   int           mW;
   logic         mTmo;
   logic [1:0]   mPtr;
   logic [31:0]  mArg;
   logic         mErr;
   logic [1:0]   mId;
   logic [3:0]   lastAck;
   logic         prevDnReq;
   int           ackLog[$];

   mod_call_arbiter #(
      .N(4),
      .WIDTH(32),
      .TIMEOUT(TMO)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .up_req(up_req),
      .up_arg(up_arg),
      .up_ack(up_ack),
      .dn_req(dn_req),
      .dn_arg(dn_arg),
      .dn_ack(dn_ack),
      .err_clr(err_clr),
      .busy(busy),
      .timeout_err(timeout_err),
      .err_id(err_id)
   );

   // Free-running clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   assign up_arg = {args[3], args[2], args[1], args[0]};

   // Downstream model: dn_ack echoes dn_req after dsSel+1 cycles, or stays low when stuck
   always @(posedge clk) begin
      if (!rst_n) dnHist <= '0;
      else        dnHist <= {dnHist[6:0], dn_req};
   end
   assign dn_ack = !ackStuck && dnHist[dsSel];

   task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectorCount++;
      assert (obs === exp)
      else begin
         missCount++;
         $error("[TB] FAIL %s: observed %0h, expected %0h", tag, obs, exp);
      end
   endtask

   function automatic int pickWinner(input logic [3:0] req, input logic [1:0] ptr);
      for (int k = 0; k < 4; k++) begin
         int i;
         i = (int'(ptr) + k) % 4;
         if (req[i]) return i;
      end
      return 0;
   endfunction

   // Phase lengths of one call: CALL lasts until the echo arrives, DRAIN until it leaves
   task automatic planCall();
      int d;
      d = int'(dsSel) + 1;
      if (ackStuck) begin
         mC   = TMO;
         mEnd = TMO + 1;
         mTmo = 1'b1;
      end else begin
         mC   = d + 1;
         mEnd = 2 * d + 2;
         mTmo = 1'b0;
      end
   endtask

   function automatic int logAt(input int i);
      if (i < ackLog.size()) return ackLog[i];
      return -1;
   endfunction

   task automatic applyStimulus(input int idx, input logic [31:0] arg);
      if (!up_req[idx]) begin
         args[idx]   = arg;
         up_req[idx] = 1'b1;
      end
   endtask

   // One clock: advance the model across the edge, run the requesters, compare every output
   task automatic tick();
      logic [3:0] reqS;
      logic       rstS;
      logic       clrS;
      logic [3:0] expAck;
      reqS = up_req;
      rstS = rst_n;
      clrS = err_clr;
      @(posedge clk);
      #1;
      if (!rstS) begin
         mN   = 0;
         mPtr = 2'd0;
         mErr = 1'b0;
         mId  = 2'd0;
         mArg = '0;
      end else begin
         if (clrS) begin
            mErr = 1'b0;
            mId  = 2'd0;
         end
         if (mN == 0) begin
            if (reqS != 4'd0) begin
               mW   = pickWinner(reqS, mPtr);
               mArg = args[mW];
               planCall();
               mN   = 1;
            end
         end else begin
            if (mTmo && mN == mC) begin
               if (!mErr) mId = 2'(mW);
               mErr = 1'b1;
            end
            if (mN == mEnd + 1) begin
               mPtr = 2'((mW + 1) % 4);
               mN   = 0;
            end else begin
               mN++;
            end
         end
      end
      up_req = up_req & ~lastAck;
      if (autoRe) up_req = up_req | lastAck;
      lastAck = up_ack;
      for (int j = 0; j < 4; j++) if (up_ack[j]) ackLog.push_back(j);
      expAck = (mN != 0 && mN == mEnd + 1) ? 4'(1 << mW) : 4'd0;
      checkOutput("busy", busy, mN != 0);
      checkOutput("dn_req", dn_req, mN >= 1 && mN <= mC);
      checkOutput("up_ack", up_ack, expAck);
      checkOutput("dn_arg", dn_arg, mArg);
      checkOutput("timeout_err", timeout_err, mErr);
      checkOutput("err_id", err_id, mId);
      if (dn_req && !prevDnReq) checkOutput("dn_req rise while dn_ack high", dn_ack, 1'b0);
      prevDnReq = dn_req;
   endtask

   task automatic waitAcks(input int n, input int budget);
      int target;
      int b;
      target = ackLog.size() + n;
      b = 0;
      while (ackLog.size() < target && b < budget) begin
         tick();
         b++;
      end
      checkOutput("ack wait budget", ackLog.size() >= target, 1'b1);
   endtask

   task automatic waitQuiet(input int budget);
      int b;
      b = 0;
      while ((up_req != 4'd0 || mN != 0 || dnHist != 8'd0) && b < budget) begin
         tick();
         b++;
      end
      checkOutput("quiet wait budget", up_req == 4'd0 && mN == 0 && dnHist == 8'd0, 1'b1);
   endtask

   task automatic pulseReset();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
   endtask

   // Directed scenarios, then random traffic, then the summary
   initial begin
      int base;
      rst_n     = 1'b0;
      up_req    = '0;
      err_clr   = 1'b0;
      dsSel     = 3'd0;
      ackStuck  = 1'b0;
      autoRe    = 1'b0;
      lastAck   = '0;
      prevDnReq = 1'b0;
      mN = 0; mC = 0; mEnd = 0; mW = 0; mTmo = 1'b0;
      mPtr = 2'd0; mArg = '0; mErr = 1'b0; mId = 2'd0;
      for (int i = 0; i < 4; i++) args[i] = '0;

      tick();
      tick();
      rst_n = 1'b1;
      checkOutput("reset dn_arg", dn_arg, 32'd0);
      checkOutput("reset up_ack", up_ack, 4'd0);
      checkOutput("reset busy", busy, 1'b0);

      // Single call with a one-cycle downstream
      applyStimulus(0, 32'h2A);
      for (int k = 1; k <= 6; k++) begin
         tick();
         if (k <= 2) checkOutput("single dn_arg", dn_arg, 32'h2A);
         checkOutput("single dn_req", dn_req, k <= 2);
         checkOutput("single up_ack", up_ack, (k == 5) ? 4'b0001 : 4'b0000);
      end

      // Pointer is now 1: requesters 0 and 2 together
      applyStimulus(0, $urandom);
      applyStimulus(2, $urandom);
      base = ackLog.size();
      waitAcks(2, 40);
      checkOutput("ptr1 first grant", logAt(base), 2);
      checkOutput("ptr1 second grant", logAt(base + 1), 0);
      waitQuiet(20);

      // All four requesting continuously from reset
      pulseReset();
      for (int i = 0; i < 4; i++) applyStimulus(i, $urandom);
      autoRe = 1'b1;
      base = ackLog.size();
      waitAcks(5, 80);
      autoRe = 1'b0;
      for (int k = 0; k < 5; k++) checkOutput("rotation order", logAt(base + k), k % 4);
      waitQuiet(100);

      // Stuck downstream: two timeouts, first offender kept, then cleared
      ackStuck = 1'b1;
      applyStimulus(3, $urandom);
      waitAcks(1, 40);
      checkOutput("timeout flag", timeout_err, 1'b1);
      checkOutput("timeout id", err_id, 2'd3);
      applyStimulus(1, $urandom);
      waitAcks(1, 40);
      checkOutput("second timeout flag", timeout_err, 1'b1);
      checkOutput("second timeout keeps id", err_id, 2'd3);
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
      checkOutput("clear flag", timeout_err, 1'b0);
      checkOutput("clear id", err_id, 2'd0);
      waitQuiet(20);
      ackStuck = 1'b0;

      // Reset in the middle of a call: held requests re-arbitrated from pointer 0
      applyStimulus(3, $urandom);
      applyStimulus(1, $urandom);
      tick();
      tick();
      pulseReset();
      checkOutput("midcall reset dn_req", dn_req, 1'b0);
      checkOutput("midcall reset up_ack", up_ack, 4'd0);
      checkOutput("midcall reset busy", busy, 1'b0);
      base = ackLog.size();
      waitAcks(2, 40);
      checkOutput("post reset first grant", logAt(base), 1);
      checkOutput("post reset second grant", logAt(base + 1), 3);
      waitQuiet(20);

      // Slow downstream with a second request arriving mid-call
      dsSel = 3'd4;
      applyStimulus(0, $urandom);
      tick();
      tick();
      tick();
      applyStimulus(2, $urandom);
      base = ackLog.size();
      waitAcks(2, 60);
      checkOutput("slow first grant", logAt(base), 0);
      checkOutput("slow second grant", logAt(base + 1), 2);
      waitQuiet(30);

      // Random traffic with varying downstream delay
      for (int i = 0; i < 400; i++) begin
         if (mN == 0 && dnHist == 8'd0 && $urandom_range(0, 3) == 0) dsSel = 3'($urandom_range(0, 4));
         for (int j = 0; j < 4; j++) begin
            if ($urandom_range(0, 5) == 0) applyStimulus(j, $urandom);
         end
         err_clr = ($urandom_range(0, 15) == 0);
         tick();
      end
      err_clr = 1'b0;
      waitQuiet(300);

      $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
      $finish;
   end

endmodule
